// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between an icache (read-only) and a
// dcache (read/write) requester. Grants one transaction at a time, with at
// least one IDLE cycle between grants and round-robin on contention. Each
// transaction ends on RAM ACCESS (completion) or on ERROR / timeout (abort,
// which also sets a sticky error flag).
module ram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    // icache port
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache port
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM port
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    // status
    output logic        err
);

    // Counter wide enough to hold TIMEOUT itself.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W + 1)'(TIMEOUT);

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DSERV = 2'b01,
        ISERV = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_d_q, last_d_d;   // previous grant was the dcache
    logic             err_q, err_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      store_q, store_d;
    logic             write_q, write_d;

    logic             done;                 // ACCESS this cycle
    logic             abort;                // ERROR or timeout this cycle
    logic [CNT_W:0]   cnt_inc;              // wait count including this cycle

    assign err = err_q;

    // Control state: synchronous active-high reset.
    // NOTE: sequential state uses non-blocking (<=) so all flops sample
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
            err_q    <= err_d;
        end
    end

    // Latched transaction fields.
    // NOTE: no reset on the datapath latches; they are only observed while
    // in a service state, which is always entered through a load.
    always_ff @(posedge CLK) begin
        addr_q  <= addr_d;
        store_q <= store_d;
        write_q <= write_d;
    end

    // Next-state, grant selection, RAM drive and completion/abort outputs.
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d_d = last_d_q;
        err_d    = err_q;
        addr_d   = addr_q;
        store_d  = store_q;
        write_d  = write_q;

        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        done     = 1'b0;
        abort    = 1'b0;
        cnt_inc  = {1'b0, cnt_q} + (CNT_W + 1)'(1);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // dcache has priority unless the icache is also waiting and
                // the dcache was served last time.
                if ((dREN || dWEN) && !(iREN && last_d_q)) begin
                    state_d  = DSERV;
                    last_d_d = 1'b1;
                    addr_d   = daddr;
                    store_d  = dstore;
                    write_d  = dWEN;        // read+write together is a write
                end else if (iREN) begin
                    state_d  = ISERV;
                    last_d_d = 1'b0;
                    addr_d   = iaddr;
                    store_d  = '0;
                    write_d  = 1'b0;
                end
            end

            DSERV, ISERV: begin
                ramREN   = !write_q;
                ramWEN   = write_q;
                ramaddr  = addr_q;
                ramstore = store_q;

                done  = (ramstate == RAM_ACCESS);
                abort = !done && ((ramstate == RAM_ERROR) || (cnt_inc >= TIMEOUT_LIM));

                if (done || abort) begin
                    state_d = IDLE;
                    if (state_q == DSERV) begin
                        dwait = 1'b0;
                        dload = done ? ramload : '0;
                    end else begin
                        iwait = 1'b0;
                        iload = done ? ramload : '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (abort) begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a transaction-level reference model
// is compared against every DUT output on every falling edge, while a
// driver runs directed scenarios (with literal expectations) followed by
// randomized traffic.
module tb_ram_arbiter;

    localparam int unsigned TO = 8;

    localparam logic [1:0] ST_FREE   = 2'b00;
    localparam logic [1:0] ST_BUSY   = 2'b01;
    localparam logic [1:0] ST_ACCESS = 2'b10;
    localparam logic [1:0] ST_ERROR  = 2'b11;

    localparam int NONE   = 0;
    localparam int DCACHE = 1;
    localparam int ICACHE = 2;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    ram_arbiter #(.TIMEOUT(TO)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: one active transaction record (or none), the
    // cycles it has waited, who was granted last, and the sticky error.
    // Outputs are derived from that record; the record advances on the
    // rising edge using the inputs that were stable at the falling edge.
    // ------------------------------------------------------------------
    int          m_who    = NONE;
    bit          m_write  = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_data   = '0;
    int          m_waited = 0;
    bit          m_last_d = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_on     = 1'b0;

    initial begin
        logic        e_iwait, e_dwait, e_ren, e_wen;
        logic [31:0] e_iload, e_dload, e_addr, e_store;
        bit          ok, bad, want_d;
        int          grab;
        forever begin
            @(negedge CLK);
            e_iwait = 1'b1; e_dwait = 1'b1;
            e_iload = '0;   e_dload = '0;
            e_ren   = 1'b0; e_wen   = 1'b0;
            e_addr  = '0;   e_store = '0;
            ok = 1'b0; bad = 1'b0;
            if (m_who != NONE) begin
                e_ren   = !m_write;
                e_wen   = m_write;
                e_addr  = m_addr;
                e_store = m_data;
                ok  = (ramstate == ST_ACCESS);
                bad = !ok && ((ramstate == ST_ERROR) || (m_waited + 1 >= int'(TO)));
                if (ok || bad) begin
                    if (m_who == DCACHE) begin
                        e_dwait = 1'b0;
                        e_dload = ok ? ramload : 32'h0;
                    end else begin
                        e_iwait = 1'b0;
                        e_iload = ok ? ramload : 32'h0;
                    end
                end
            end

            if (m_on) begin
                check("model iwait",    {31'b0, iwait},  {31'b0, e_iwait});
                check("model dwait",    {31'b0, dwait},  {31'b0, e_dwait});
                check("model iload",    iload,           e_iload);
                check("model dload",    dload,           e_dload);
                check("model ramREN",   {31'b0, ramREN}, {31'b0, e_ren});
                check("model ramWEN",   {31'b0, ramWEN}, {31'b0, e_wen});
                check("model ramaddr",  ramaddr,         e_addr);
                check("model ramstore", ramstore,        e_store);
                check("model err",      {31'b0, err},    {31'b0, m_err});
            end

            if (RST) begin
                m_who = NONE; m_waited = 0; m_last_d = 1'b0; m_err = 1'b0; m_on = 1'b1;
            end else if (m_who == NONE) begin
                want_d = dREN || dWEN;
                if (want_d && iREN) grab = m_last_d ? ICACHE : DCACHE;
                else if (want_d)    grab = DCACHE;
                else if (iREN)      grab = ICACHE;
                else                grab = NONE;
                if (grab == DCACHE) begin
                    m_write = dWEN; m_addr = daddr; m_data = dstore; m_last_d = 1'b1;
                end else if (grab == ICACHE) begin
                    m_write = 1'b0; m_addr = iaddr; m_data = '0; m_last_d = 1'b0;
                end
                m_who    = grab;
                m_waited = 0;
            end else if (ok || bad) begin
                m_err = m_err || bad;
                m_who = NONE;
            end else begin
                m_waited++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: directed scenarios with literal expectations, then random.
    // ------------------------------------------------------------------
    initial begin
        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = ST_FREE;
        step(); step();
        RST = 1'b0;
        @(negedge CLK);
        check("reset iwait",  {31'b0, iwait},  32'd1);
        check("reset dwait",  {31'b0, dwait},  32'd1);
        check("reset ramREN", {31'b0, ramREN}, 32'd0);
        check("reset ramWEN", {31'b0, ramWEN}, 32'd0);
        check("reset err",    {31'b0, err},    32'd0);
        step();

        // icache read, three BUSY cycles then ACCESS; request dropped early.
        iREN = 1'b1; iaddr = 32'h40;
        step();
        iREN = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            ramstate = (c == 4) ? ST_ACCESS : ST_BUSY;
            ramload  = 32'hDEADBEEF;
            @(negedge CLK);
            check("ird ramREN",  {31'b0, ramREN}, 32'd1);
            check("ird ramaddr", ramaddr, 32'h40);
            check("ird iwait",   {31'b0, iwait}, (c == 4) ? 32'd0 : 32'd1);
            if (c == 4) check("ird iload", iload, 32'hDEADBEEF);
            step();
        end
        ramstate = ST_FREE;
        @(negedge CLK);
        check("ird idle ramREN", {31'b0, ramREN}, 32'd0);
        check("ird idle iwait",  {31'b0, iwait},  32'd1);
        step();

        // dcache write, immediate ACCESS.
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678;
        step();
        dWEN = 1'b0; ramstate = ST_ACCESS;
        @(negedge CLK);
        check("dwr ramWEN",   {31'b0, ramWEN}, 32'd1);
        check("dwr ramREN",   {31'b0, ramREN}, 32'd0);
        check("dwr ramstore", ramstore, 32'h12345678);
        check("dwr dwait",    {31'b0, dwait},  32'd0);
        step();
        ramstate = ST_FREE;
        @(negedge CLK);
        check("dwr done dwait",  {31'b0, dwait},  32'd1);
        check("dwr done ramWEN", {31'b0, ramWEN}, 32'd0);
        step();

        // Contention with both requests held: D, I, D, I with idle gaps.
        RST = 1'b1;
        step();
        RST = 1'b0; dREN = 1'b1; iREN = 1'b1; daddr = 32'h100; iaddr = 32'h200;
        ramstate = ST_ACCESS;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check("alt dwait", {31'b0, dwait}, (k % 4 == 1) ? 32'd0 : 32'd1);
            check("alt iwait", {31'b0, iwait}, (k % 4 == 3) ? 32'd0 : 32'd1);
            step();
        end
        dREN = 1'b0; iREN = 1'b0; ramstate = ST_FREE;
        step();

        // dcache read held BUSY until timeout.
        dREN = 1'b1; daddr = 32'h300; ramstate = ST_BUSY; ramload = 32'h55AA55AA;
        step();
        dREN = 1'b0;
        for (int c = 1; c <= int'(TO); c++) begin
            @(negedge CLK);
            check("tmo dwait", {31'b0, dwait}, (c == int'(TO)) ? 32'd0 : 32'd1);
            check("tmo dload", dload, 32'h0);
            check("tmo err",   {31'b0, err}, 32'd0);
            step();
        end
        @(negedge CLK);
        check("tmo err set", {31'b0, err}, 32'd1);
        step(); step(); step();
        @(negedge CLK);
        check("tmo err sticky", {31'b0, err}, 32'd1);
        step();

        // icache read aborted by ERROR.
        RST = 1'b1;
        step();
        RST = 1'b0; iREN = 1'b1; iaddr = 32'h44; ramstate = ST_FREE;
        step();
        iREN = 1'b0; ramstate = ST_BUSY; ramload = 32'hCAFEF00D;
        @(negedge CLK);
        check("ierr busy iwait", {31'b0, iwait}, 32'd1);
        step();
        ramstate = ST_ERROR;
        @(negedge CLK);
        check("ierr iwait",  {31'b0, iwait},  32'd0);
        check("ierr iload",  iload,           32'h0);
        check("ierr ramREN", {31'b0, ramREN}, 32'd1);
        step();
        ramstate = ST_FREE;
        @(negedge CLK);
        check("ierr err", {31'b0, err}, 32'd1);
        step();

        // Reset in the middle of a BUSY dcache write (err is still set).
        dWEN = 1'b1; daddr = 32'h500; dstore = 32'hA5A5A5A5;
        step();
        dWEN = 1'b0; ramstate = ST_BUSY;
        @(negedge CLK);
        check("rst pre ramWEN", {31'b0, ramWEN}, 32'd1);
        check("rst pre err",    {31'b0, err},    32'd1);
        step();
        RST = 1'b1;
        @(negedge CLK);
        check("rst cyc dwait",  {31'b0, dwait},  32'd1);
        check("rst cyc ramWEN", {31'b0, ramWEN}, 32'd1);
        step();
        RST = 1'b0;
        @(negedge CLK);
        check("rst post ramWEN",  {31'b0, ramWEN}, 32'd0);
        check("rst post dwait",   {31'b0, dwait},  32'd1);
        check("rst post err",     {31'b0, err},    32'd0);
        check("rst post ramaddr", ramaddr,         32'h0);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            RST    = ($urandom_range(0, 299) == 0);
            iREN   = ($urandom_range(0, 99) < 45);
            dREN   = ($urandom_range(0, 99) < 35);
            dWEN   = ($urandom_range(0, 99) < 30);
            iaddr  = $urandom;
            daddr  = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 99);
            if (r < 30)      ramstate = ST_ACCESS;
            else if (r < 33) ramstate = ST_ERROR;
            else if (r < 70) ramstate = ST_BUSY;
            else             ramstate = ST_FREE;
            step();
        end

        RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = ST_FREE;
        step(); step();
        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
